// File: rtl/pbkdf2_f_block.sv
// PBKDF2-HMAC-SHA256 F-function controller.
// Computes one derived-key block T = U1 ^ U2 ^ ... ^ Uc by driving a single
// hmac_sha256 instance over its valid/ready ports and XOR-folding each PRF result.
module pbkdf2_f_block #(
    parameter int unsigned ITER_WIDTH_P = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [511:0]            pw_i,
    input  logic [511:0]            salt_i,
    input  logic [5:0]              salt_len_i,
    input  logic [ITER_WIDTH_P-1:0] iter_i,
    input  logic [31:0]             blk_idx_i,
    input  logic                    v_i,
    output logic                    r_o,
    output logic [255:0]            dk_o,
    output logic                    v_o,
    input  logic                    r_i,
    output logic [511:0]            hmac_key_o,
    output logic [511:0]            hmac_msg_o,
    output logic [5:0]              hmac_len_o,
    output logic                    hmac_v_o,
    input  logic                    hmac_r_i,
    input  logic [255:0]            hmac_prf_i,
    input  logic                    hmac_v_i,
    output logic                    hmac_r_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ITER_WIDTH_P-1:0] cnt_q;
    logic [255:0]            acc_q;
    logic [511:0]            first_msg;
    logic [31:0]             len32;
    logic                    hmac_xfer;
    logic                    last_iter;

    assign len32     = {26'd0, salt_len_i};
    assign hmac_xfer = hmac_v_o & hmac_r_i;
    assign last_iter = (cnt_q == ITER_WIDTH_P'(1));

    // First HMAC message: salt bytes, then big-endian block index, then zero fill.
    always_comb begin
        first_msg = '0;
        for (int unsigned b = 0; b < 64; b++) begin
            if (b < len32) begin
                first_msg[511 - 8*b -: 8] = salt_i[511 - 8*b -: 8];
            end else if (b < len32 + 32'd4) begin
                first_msg[511 - 8*b -: 8] = blk_idx_i[31 - 8*(b - len32) -: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_d  = state_q;
        r_o      = 1'b0;
        v_o      = 1'b0;
        hmac_r_o = 1'b0;
        case (state_q)
            IDLE: begin
                r_o = 1'b1;
                if (v_i) state_d = ISSUE;
            end
            ISSUE: begin
                if (hmac_xfer) state_d = WAIT;
            end
            WAIT: begin
                hmac_r_o = 1'b1;
                if (hmac_v_i) state_d = last_iter ? DONE : ISSUE;
            end
            DONE: begin
                v_o = 1'b1;
                if (r_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: request capture, HMAC issue strobe, XOR accumulation and result.
    // hmac_v_o is registered so the first ISSUE cycle is the idle gap that
    // separates an HMAC result from the next issue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hmac_key_o <= '0;
            hmac_msg_o <= '0;
            hmac_len_o <= '0;
            hmac_v_o   <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            dk_o       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (v_i) begin
                        hmac_key_o <= pw_i;
                        hmac_msg_o <= first_msg;
                        hmac_len_o <= salt_len_i + 6'd4;
                        cnt_q      <= (iter_i == '0) ? ITER_WIDTH_P'(1) : iter_i;
                        acc_q      <= '0;
                    end
                end
                ISSUE: begin
                    hmac_v_o <= ~hmac_xfer;
                end
                WAIT: begin
                    if (hmac_v_i) begin
                        acc_q <= acc_q ^ hmac_prf_i;
                        cnt_q <= cnt_q - ITER_WIDTH_P'(1);
                        if (last_iter) begin
                            dk_o <= acc_q ^ hmac_prf_i;
                        end else begin
                            hmac_msg_o <= {hmac_prf_i, 256'd0};
                            hmac_len_o <= 6'd32;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pbkdf2_f_block.sv
// Self-checking bench for pbkdf2_f_block: a behavioural HMAC-SHA256 responder
// and a PBKDF2 reference model built from byte queues.
module tb_pbkdf2_f_block;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [511:0] pw;
        logic [511:0] salt;
        logic [5:0]   len;
        logic [31:0]  iter;
        logic [31:0]  idx;
        logic [255:0] dk;
    } vec_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] PW_T   = {64'h70617373776f7264, 448'd0};
    localparam logic [511:0] SALT_T = {32'h73616c74, 480'd0};
    localparam logic [255:0] DK_C1    = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
    localparam logic [255:0] DK_C2    = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
    localparam logic [255:0] DK_C4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [511:0] pw_i = '0;
    logic [511:0] salt_i = '0;
    logic [5:0]   salt_len_i = '0;
    logic [31:0]  iter_i = '0;
    logic [31:0]  blk_idx_i = '0;
    logic         v_i = 1'b0;
    logic         r_o;
    logic [255:0] dk_o;
    logic         v_o;
    logic         r_i = 1'b0;
    logic [511:0] hmac_key_o;
    logic [511:0] hmac_msg_o;
    logic [5:0]   hmac_len_o;
    logic         hmac_v_o;
    logic         hmac_r_i = 1'b0;
    logic [255:0] hmac_prf_i = '0;
    logic         hmac_v_i = 1'b0;
    logic         hmac_r_o;

    int n_checks = 0;
    int n_fail   = 0;
    int issues   = 0;

    always #5 clk = ~clk;

    pbkdf2_f_block #(.ITER_WIDTH_P(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .pw_i(pw_i), .salt_i(salt_i), .salt_len_i(salt_len_i),
        .iter_i(iter_i), .blk_idx_i(blk_idx_i), .v_i(v_i), .r_o(r_o), .dk_o(dk_o), .v_o(v_o),
        .r_i(r_i), .hmac_key_o(hmac_key_o), .hmac_msg_o(hmac_msg_o), .hmac_len_o(hmac_len_o),
        .hmac_v_o(hmac_v_o), .hmac_r_i(hmac_r_i), .hmac_prf_i(hmac_prf_i), .hmac_v_i(hmac_v_i),
        .hmac_r_o(hmac_r_o)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256(input byte_q_t m);
        byte_q_t p;
        logic [31:0] h [8];
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        longint unsigned bitlen;
        p = m;
        bitlen = longint'(m.size()) * 8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bitlen >> (8 * i)));
        h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int blk = 0; blk < p.size() / 64; blk++) begin
            for (int t = 0; t < 16; t++)
                w[t] = {p[blk*64 + 4*t], p[blk*64 + 4*t + 1], p[blk*64 + 4*t + 2], p[blk*64 + 4*t + 3]};
            for (int t = 16; t < 64; t++)
                w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
                t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    function automatic logic [255:0] hmac(input logic [511:0] key, input byte_q_t m);
        byte_q_t inner, outer;
        logic [255:0] ih;
        for (int i = 0; i < 64; i++) inner.push_back(key[511 - 8*i -: 8] ^ 8'h36);
        foreach (m[j]) inner.push_back(m[j]);
        ih = sha256(inner);
        for (int i = 0; i < 64; i++) outer.push_back(key[511 - 8*i -: 8] ^ 8'h5c);
        for (int i = 0; i < 32; i++) outer.push_back(ih[255 - 8*i -: 8]);
        return sha256(outer);
    endfunction

    function automatic logic [255:0] pbkdf2_ref(input logic [511:0] pw, input logic [511:0] salt,
                                                input int len, input logic [31:0] iter, input logic [31:0] idx);
        byte_q_t m;
        logic [255:0] u, t;
        longint unsigned c;
        for (int i = 0; i < len; i++) m.push_back(salt[511 - 8*i -: 8]);
        for (int i = 0; i < 4; i++) m.push_back(idx[31 - 8*i -: 8]);
        u = hmac(pw, m);
        t = u;
        c = (iter == 0) ? 1 : longint'(iter);
        for (longint unsigned j = 1; j < c; j++) begin
            m.delete();
            for (int i = 0; i < 32; i++) m.push_back(u[255 - 8*i -: 8]);
            u = hmac(pw, m);
            t ^= u;
        end
        return t;
    endfunction

    // HMAC responder: samples at negedge (values the DUT sees on the next edge), updates after it.
    byte_q_t      rsp_m;
    logic [255:0] rsp_prf;
    int           rsp_lat = 0;
    bit           rsp_busy = 0;
    always @(negedge clk) begin
        if (rst_i) begin
            rsp_busy = 0;
            @(posedge clk); #1;
            hmac_r_i = 1'b1;
            hmac_v_i = 1'b0;
        end else if (hmac_v_o && hmac_r_i) begin
            rsp_m.delete();
            for (int i = 0; i < int'(hmac_len_o); i++) rsp_m.push_back(hmac_msg_o[511 - 8*i -: 8]);
            rsp_prf  = hmac(hmac_key_o, rsp_m);
            rsp_lat  = int'($urandom_range(1, 3));
            rsp_busy = 1;
            issues++;
            @(posedge clk); #1;
            hmac_r_i = 1'b0;
        end else if (hmac_v_i && hmac_r_o) begin
            @(posedge clk); #1;
            hmac_v_i = 1'b0;
            hmac_r_i = 1'($urandom_range(0, 1));
        end else if (rsp_busy) begin
            rsp_lat--;
            if (rsp_lat == 0) begin
                rsp_busy = 0;
                @(posedge clk); #1;
                hmac_prf_i = rsp_prf;
                hmac_v_i   = 1'b1;
            end
        end else if (!hmac_r_i) begin
            @(posedge clk); #1;
            hmac_r_i = 1'b1;
        end
    end

    // Protocol monitor: invariants and valid-hold stability on both channels.
    logic         p_hv = 0, p_hr = 0, p_v = 0, p_r = 0, p_rst = 1;
    logic [511:0] p_key, p_msg;
    logic [5:0]   p_len;
    logic [255:0] p_dk;
    always @(negedge clk) begin
        if (!rst_i && !p_rst) begin
            if (r_o && v_o) chk("inv_r_v", 512'({r_o, v_o}), 512'(2'b10));
            if (hmac_v_o && hmac_r_o) chk("inv_hv_hr", 512'({hmac_v_o, hmac_r_o}), 512'(2'b10));
            if (p_hv && !p_hr) begin
                chk("hold_hmac_v", 512'(hmac_v_o), 512'(1));
                chk("hold_hmac_msg", hmac_msg_o, p_msg);
                chk("hold_hmac_key", hmac_key_o, p_key);
                chk("hold_hmac_len", 512'(hmac_len_o), 512'(p_len));
            end
            if (p_v && !p_r) begin
                chk("hold_v_o", 512'(v_o), 512'(1));
                chk("hold_dk", 512'(dk_o), 512'(p_dk));
            end
        end
        p_hv = hmac_v_o; p_hr = hmac_r_i; p_v = v_o; p_r = r_i; p_rst = rst_i;
        p_key = hmac_key_o; p_msg = hmac_msg_o; p_len = hmac_len_o; p_dk = dk_o;
    end

    task automatic load(input vec_t v);
        pw_i = v.pw; salt_i = v.salt; salt_len_i = v.len; iter_i = v.iter; blk_idx_i = v.idx;
    endtask

    task automatic wait_ready(input string name);
        int budget = 0;
        while (!r_o && budget < 100) begin @(posedge clk); #1; budget++; end
        chk({name, "_ready"}, 512'(r_o), 512'(1));
    endtask

    // One full request: accept, wait for v_o, hold r_i low for `hold` cycles, check, release.
    task automatic do_req(input vec_t v, input int hold, input bit t5, input string name);
        int budget, iss0, c_eff;
        c_eff = (v.iter == 0) ? 1 : int'(v.iter);
        wait_ready(name);
        load(v);
        iss0 = issues;
        v_i = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0;
        chk({name, "_busy_r_o"}, 512'(r_o), 512'(0));
        budget = 0;
        while (!v_o && budget < c_eff * 16 + 64) begin @(posedge clk); #1; budget++; end
        chk({name, "_v_o"}, 512'(v_o), 512'(1));
        for (int k = 0; k < hold; k++) begin
            if (t5 && k == 10) begin pw_i = PW_T; salt_i = SALT_T; salt_len_i = 6'd4; iter_i = 32'd1; v_i = 1'b1; end
            if (t5 && k == 12) v_i = 1'b0;
            if (t5 && k == 20) begin hmac_prf_i = {8{$urandom}}; hmac_v_i = 1'b1; end
            if (t5 && k == 21) hmac_v_i = 1'b0;
            @(posedge clk); #1;
            if (t5) begin
                chk({name, "_hold_v_o"}, 512'(v_o), 512'(1));
                chk({name, "_hold_r_o"}, 512'(r_o), 512'(0));
                chk({name, "_hold_dk"}, 512'(dk_o), 512'(v.dk));
            end
        end
        chk({name, "_dk"}, 512'(dk_o), 512'(v.dk));
        chk({name, "_issues"}, 512'(issues - iss0), 512'(c_eff));
        r_i = 1'b1;
        @(posedge clk); #1;
        r_i = 1'b0;
        chk({name, "_idle_r_o"}, 512'(r_o), 512'(1));
        chk({name, "_idle_v_o"}, 512'(v_o), 512'(0));
        if (t5) begin
            iss0 = issues;
            repeat (5) @(posedge clk);
            #1;
            chk({name, "_no_new_issue"}, 512'(issues - iss0), 512'(0));
            chk({name, "_still_idle"}, 512'(r_o), 512'(1));
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_r_o"}, 512'(r_o), 512'(1));
        chk({name, "_v_o"}, 512'(v_o), 512'(0));
        chk({name, "_hmac_v_o"}, 512'(hmac_v_o), 512'(0));
        chk({name, "_hmac_r_o"}, 512'(hmac_r_o), 512'(0));
        chk({name, "_dk_o"}, 512'(dk_o), 512'(0));
        chk({name, "_key"}, hmac_key_o, 512'(0));
        chk({name, "_msg"}, hmac_msg_o, 512'(0));
        chk({name, "_len"}, 512'(hmac_len_o), 512'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        vec_t v3;
        int   budget, iss0;

        vecs[0] = '{pw: PW_T, salt: SALT_T, len: 6'd4, iter: 32'd1, idx: 32'd1, dk: DK_C1};
        vecs[1] = '{pw: PW_T, salt: SALT_T, len: 6'd4, iter: 32'd2, idx: 32'd1, dk: DK_C2};
        vecs[2] = '{pw: PW_T, salt: SALT_T, len: 6'd4, iter: 32'd0, idx: 32'd1, dk: DK_C1};
        for (int n = 3; n < 10; n++) begin
            for (int k = 0; k < 16; k++) begin
                vecs[n].pw[32*k +: 32]   = $urandom;
                vecs[n].salt[32*k +: 32] = $urandom;
            end
            vecs[n].len  = (n == 3) ? 6'd0 : (n == 4) ? 6'd59 : 6'($urandom_range(0, 59));
            vecs[n].iter = 32'($urandom_range(0, 5));
            vecs[n].idx  = $urandom;
            vecs[n].dk   = pbkdf2_ref(vecs[n].pw, vecs[n].salt, int'(vecs[n].len), vecs[n].iter, vecs[n].idx);
        end

        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_i = 1'b0;
        @(posedge clk); #1;
        chk_reset("post_reset");

        for (int n = 0; n < 10; n++) begin
            do_req(vecs[n], int'($urandom_range(0, 3)), 1'b0, $sformatf("vec%0d", n));
        end

        v3 = '{pw: PW_T, salt: SALT_T, len: 6'd4, iter: 32'd4096, idx: 32'd1, dk: DK_C4096};
        do_req(v3, 1, 1'b0, "t3_c4096");

        do_req(vecs[1], 50, 1'b1, "t5_hold");

        wait_ready("t6");
        load(v3);
        iss0 = issues;
        v_i = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0;
        budget = 0;
        while (issues - iss0 < 100 && budget < 3000) begin @(posedge clk); #1; budget++; end
        chk("t6_reach_iter100", 512'(issues - iss0), 512'(100));
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk_reset("t6_reset");
        do_req(vecs[0], 2, 1'b0, "t6_after_t1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
